// File: rtl/div_pkg.sv
// Shared state encoding, default width and saturation helper for the signed divider.
// Constants only; no latency or flow control of its own.
package div_pkg;

   localparam int DIV_N = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ITER = 2'b01,
      FIX  = 2'b10
   } div_state_t;

   // Largest positive or most negative n-bit two's-complement value, LSB-aligned.
   function automatic logic [31:0] sat_const(input logic neg, input int n);
      if (neg) return 32'hFFFF_FFFF << (n - 1);
      return (32'h1 << (n - 1)) - 32'h1;
   endfunction

endpackage

// File: rtl/signed_divider_if.sv
// Start/operand/result bundle for the signed divider.
// The master drives en and operands; the slave returns results with a done pulse, no backpressure.
interface signed_divider_if import div_pkg::*; #(parameter int N = DIV_N);

   logic           en;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic [N-1:0]   quotient;
   logic [N-1:0]   remainder;
   logic           done;
   logic           busy;
   logic           ovf;
   logic           dz;

   modport master (
      output en, dividend, divisor,
      input  quotient, remainder, done, busy, ovf, dz
   );

   modport slave (
      input  en, dividend, divisor,
      output quotient, remainder, done, busy, ovf, dz
   );

endinterface

// File: rtl/div_restore_step.sv
// One restoring shift/subtract iteration on unsigned magnitudes.
// Combinational, zero latency, no flow control.
module div_restore_step import div_pkg::*; #(
   parameter int N = DIV_N
) (
   input  logic [N:0]     r,
   input  logic [2*N-1:0] q,
   input  logic [N-1:0]   d,
   output logic [N:0]     r_nxt,
   output logic [2*N-1:0] q_nxt
);

   logic [N+1:0] r_sh;
   logic         ge;

   always_comb begin
      r_sh  = {r, q[2*N-1]};
      ge    = (r_sh >= {2'b00, d});
      r_nxt = ge ? (N+1)'(r_sh - {2'b00, d}) : (N+1)'(r_sh);
      q_nxt = {q[2*N-2:0], ge};
   end

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor, restoring loop plus sign fix.
// Result 2N+1 edges after the start edge; en is ignored while busy, nothing queues.
module signed_divider import div_pkg::*; #(
   parameter int N = DIV_N
) (
   input  logic           clk,
   input  logic           rst_n,
   signed_divider_if.slave bus
);

   localparam int             CW       = $clog2(2*N);
   localparam logic [CW-1:0]  CNT_LAST = CW'(2*N-1);
   localparam logic [2*N-1:0] LIM_NEG  = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
   localparam logic [2*N-1:0] LIM_POS  = LIM_NEG - {{(2*N-1){1'b0}}, 1'b1};

   div_state_t     state, state_nxt;
   logic [N:0]     r, r_nxt;
   logic [2*N-1:0] q, q_nxt;
   logic [N-1:0]   d;
   logic [CW-1:0]  cnt;
   logic           sign_a, sign_b, zero_div;

   logic [2*N-1:0] a_mag;
   logic [N-1:0]   b_mag;
   logic           neg_q, ovf_c;
   logic [N-1:0]   quo_c, rem_c;

   div_restore_step #(.N(N)) u_step (
      .r     (r),
      .q     (q),
      .d     (d),
      .r_nxt (r_nxt),
      .q_nxt (q_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.en) state_nxt = ITER;
         ITER:    if (cnt == CNT_LAST) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Magnitudes at capture; -(-2^(2N-1)) wraps to 2^(2N-1), which is the wanted unsigned value.
   always_comb begin
      a_mag = bus.dividend[2*N-1] ? -bus.dividend : bus.dividend;
      b_mag = bus.divisor[N-1]    ? -bus.divisor  : bus.divisor;
   end

   always_comb begin
      neg_q = sign_a ^ sign_b;
      ovf_c = neg_q ? (q > LIM_NEG) : (q > LIM_POS);
      quo_c = neg_q ? -q[N-1:0] : q[N-1:0];
      if (ovf_c) quo_c = N'(sat_const(neg_q, N));
      rem_c = sign_a ? -r[N-1:0] : r[N-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r             <= '0;
         q             <= '0;
         d             <= '0;
         cnt           <= '0;
         sign_a        <= 1'b0;
         sign_b        <= 1'b0;
         zero_div      <= 1'b0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
         bus.done      <= 1'b0;
         bus.busy      <= 1'b0;
         bus.ovf       <= 1'b0;
         bus.dz        <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.en) begin
                  q        <= a_mag;
                  d        <= b_mag;
                  r        <= '0;
                  sign_a   <= bus.dividend[2*N-1];
                  sign_b   <= bus.divisor[N-1];
                  zero_div <= (bus.divisor == '0);
                  cnt      <= '0;
                  bus.busy <= 1'b1;
               end
            end
            ITER: begin
               r   <= r_nxt;
               q   <= q_nxt;
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               // Divide-by-zero still runs the full loop so latency never depends on data.
               if (zero_div) begin
                  bus.quotient  <= '0;
                  bus.remainder <= '0;
                  bus.ovf       <= 1'b0;
               end else begin
                  bus.quotient  <= quo_c;
                  bus.remainder <= rem_c;
                  bus.ovf       <= ovf_c;
               end
               bus.dz   <= zero_div;
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_divider.sv
// Directed bench for signed_divider: hand-computed vectors, control corners, multiplier round trip.
module tb_signed_divider;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   signed_divider_if #(.N(4)) dif ();

   signed_divider #(.N(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif)
   );

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [3:0] q;
      logic [3:0] r;
      logic       ovf;
      logic       dz;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Called #1 after a rising edge; returns edges from start to done (-1 on timeout).
   task automatic run_div(input logic [7:0] a, input logic [3:0] b, input int pulse_at,
                          output int lat, output int busy1);
      dif.en       = 1'b1;
      dif.dividend = a;
      dif.divisor  = b;
      @(posedge clk); #1;
      dif.en       = 1'b0;
      dif.dividend = 8'h00;
      dif.divisor  = 4'h0;
      lat   = -1;
      busy1 = -1;
      for (int e = 1; e <= 20; e++) begin
         if (e == pulse_at) dif.en = 1'b1;
         @(posedge clk); #1;
         dif.en = 1'b0;
         if (e == 1) busy1 = int'(dif.busy);
         if (dif.done) begin
            lat = e;
            break;
         end
      end
   endtask

   task automatic chk_idle_quiet(input string tag, input int edges);
      int n_done;
      n_done = 0;
      for (int e = 0; e < edges; e++) begin
         @(posedge clk); #1;
         if (dif.done || dif.busy) n_done++;
      end
      chk(tag, n_done, 0);
   endtask

   initial begin
      int lat, busy1, first, second;
      logic [7:0] pa;
      logic [3:0] xb, yb;

      vecs[0] = '{8'h14, 4'h3, 4'h6, 4'h2, 1'b0, 1'b0};  //  20 /  3
      vecs[1] = '{8'hEC, 4'h3, 4'hA, 4'hE, 1'b0, 1'b0};  // -20 /  3
      vecs[2] = '{8'h14, 4'hD, 4'hA, 4'h2, 1'b0, 1'b0};  //  20 / -3
      vecs[3] = '{8'hEB, 4'hC, 4'h5, 4'hF, 1'b0, 1'b0};  // -21 / -4
      vecs[4] = '{8'h40, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0};  //  64 / -8
      vecs[5] = '{8'h80, 4'hF, 4'h7, 4'h0, 1'b1, 1'b0};  // -128 / -1
      vecs[6] = '{8'h80, 4'h1, 4'h8, 4'h0, 1'b1, 1'b0};  // -128 /  1
      vecs[7] = '{8'h07, 4'h8, 4'h0, 4'h7, 1'b0, 1'b0};  //   7 / -8
      vecs[8] = '{8'h2D, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};  //  45 /  0
      vecs[9] = '{8'h64, 4'h3, 4'h7, 4'h1, 1'b1, 1'b0};  // 100 /  3

      rst_n        = 1'b0;
      dif.en       = 1'b0;
      dif.dividend = 8'h00;
      dif.divisor  = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_quotient",  int'(dif.quotient),  0);
      chk("rst_remainder", int'(dif.remainder), 0);
      chk("rst_done",      int'(dif.done),      0);
      chk("rst_busy",      int'(dif.busy),      0);
      chk("rst_ovf",       int'(dif.ovf),       0);
      chk("rst_dz",        int'(dif.dz),        0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // en pulsed during the loop must neither disturb the result nor start a second op.
      run_div(8'h14, 4'h3, 3, lat, busy1);
      chk("enpulse_latency",   lat, 9);
      chk("enpulse_quotient",  int'(dif.quotient),  6);
      chk("enpulse_remainder", int'(dif.remainder), 2);
      chk_idle_quiet("enpulse_no_restart", 12);

      foreach (vecs[i]) begin
         run_div(vecs[i].a, vecs[i].b, -1, lat, busy1);
         chk($sformatf("v%0d_latency", i),   lat,   9);
         chk($sformatf("v%0d_busy", i),      busy1, 1);
         chk($sformatf("v%0d_quotient", i),  int'(dif.quotient),  int'(vecs[i].q));
         chk($sformatf("v%0d_remainder", i), int'(dif.remainder), int'(vecs[i].r));
         chk($sformatf("v%0d_ovf", i),       int'(dif.ovf),       int'(vecs[i].ovf));
         chk($sformatf("v%0d_dz", i),        int'(dif.dz),        int'(vecs[i].dz));
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_pulse", i), int'(dif.done), 0);
         chk($sformatf("v%0d_busy_after", i), int'(dif.busy), 0);
      end

      // Reset in the middle of 45/3: outputs clear, no done follows.
      dif.en       = 1'b1;
      dif.dividend = 8'h2D;
      dif.divisor  = 4'h3;
      @(posedge clk); #1;
      dif.en = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_quotient",  int'(dif.quotient),  0);
      chk("abort_remainder", int'(dif.remainder), 0);
      chk("abort_done",      int'(dif.done),      0);
      chk("abort_busy",      int'(dif.busy),      0);
      chk("abort_ovf",       int'(dif.ovf),       0);
      chk("abort_dz",        int'(dif.dz),        0);
      rst_n = 1'b1;
      chk_idle_quiet("abort_no_done", 15);

      // en held high: second op starts on the edge after the first result.
      dif.en       = 1'b1;
      dif.dividend = 8'h14;
      dif.divisor  = 4'h3;
      @(posedge clk); #1;
      dif.dividend = 8'hEB;
      dif.divisor  = 4'hC;
      first  = -1;
      second = -1;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk); #1;
         if (first > 0 && e == first + 1) dif.en = 1'b0;
         if (dif.done) begin
            if (first < 0) begin
               first = e;
               chk("b2b_first_quotient",  int'(dif.quotient),  6);
               chk("b2b_first_remainder", int'(dif.remainder), 2);
            end else begin
               second = e;
               break;
            end
         end
      end
      dif.en = 1'b0;
      chk("b2b_first_latency", first, 9);
      chk("b2b_interval",      second - first, 10);
      chk("b2b_second_quotient",  int'(dif.quotient),  5);
      chk("b2b_second_remainder", int'(dif.remainder), 15);
      @(posedge clk); #1;

      // Product of every 4-bit signed pair divided by a nonzero factor returns the other factor.
      for (int x = -8; x <= 7; x++) begin
         for (int y = -8; y <= 7; y++) begin
            if (x != 0) begin
               pa = 8'(x * y);
               xb = 4'(x);
               yb = 4'(y);
               run_div(pa, xb, -1, lat, busy1);
               chk($sformatf("rt_%0d_%0d_latency", x, y),   lat, 9);
               chk($sformatf("rt_%0d_%0d_quotient", x, y),  int'(dif.quotient),  int'(yb));
               chk($sformatf("rt_%0d_%0d_remainder", x, y), int'(dif.remainder), 0);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
